// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   uart_state_t  : transmit FSM states.
//   UART_*_OFS    : register offsets inside the two-word window.
//   STAT_*_BIT    : bit positions of the STATUS register.
//   pack_status() : assembles the 32-bit STATUS word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
  localparam logic [31:0] UART_STATUS_OFS = 32'd4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  // Upper status bits always read as zero.
  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] word;
    word                 = 32'd0;
    word[STAT_FULL_BIT]  = full;
    word[STAT_EMPTY_BIT] = empty;
    word[STAT_BUSY_BIT]  = busy;
    word[STAT_OVF_BIT]   = ovf;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory bus slice seen by the UART window.
//   MemWrite  : store strobe (core -> uart)
//   DataAddr  : byte address (core -> uart)
//   WriteData : store data, only [7:0] meaningful (core -> uart)
//   ReadData  : combinational load data (uart -> core)
//   Hit       : address falls on one of the two registers (uart -> core)
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output MemWrite, DataAddr, WriteData,
    input  ReadData, Hit
  );

  modport slave (
    input  MemWrite, DataAddr, WriteData,
    output ReadData, Hit
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data.
//   clk, rst   : clock, asynchronous active-low reset
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop/rdata  : read request; rdata shows the head entry at all times
//   full/empty : status derived from pointers (one extra wrap bit each)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Status from pointers; a same-cycle pop frees the slot a full push needs.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    rdata     = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data bus.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of mmio_uart_tx_if (MemWrite, DataAddr, WriteData,
//          ReadData, Hit); ReadData/Hit are combinational of DataAddr and state
//   Tx   : registered serial output, idle high
// Register window: BASE_ADDR+0 TXDATA (write pushes a byte, reads 0),
//                  BASE_ADDR+4 STATUS {overflow, busy, empty, full}; any
//                  store to STATUS clears the sticky overflow bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_tx_if.slave   bus,
  output logic            Tx
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          sel_txdata_s;
  logic          sel_status_s;
  logic          push_req_s;
  logic          ovf_clr_s;
  logic          pop_s;
  logic          cnt_last_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_rdata_s;
  logic          unused_wdata_s;

  uart_state_t   state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          ovf_r;

  // Only the low byte of store data is transmitted.
  assign unused_wdata_s = ^bus.WriteData[31:8];

  // Exact-address decode; misaligned or out-of-window addresses never hit.
  always_comb begin
    sel_txdata_s = (bus.DataAddr == (BASE_ADDR + UART_TXDATA_OFS));
    sel_status_s = (bus.DataAddr == (BASE_ADDR + UART_STATUS_OFS));
    bus.Hit      = sel_txdata_s | sel_status_s;
    push_req_s   = bus.MemWrite & sel_txdata_s;
    ovf_clr_s    = bus.MemWrite & sel_status_s;
    if (sel_status_s) begin
      bus.ReadData = pack_status(fifo_full_s, fifo_empty_s,
                                 (state_r != IDLE), ovf_r);
    end else begin
      bus.ReadData = 32'd0;
    end
  end

  // Pop decision depends on flop state only: idle with data, or end of stop bit.
  always_comb begin
    pop_s      = 1'b0;
    cnt_last_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE:    pop_s = !fifo_empty_s;
      STOP:    pop_s = cnt_last_s && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req_s),
    .wdata (bus.WriteData[7:0]),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sticky overflow: set when a push finds the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else if (push_req_s && fifo_full_s && !pop_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Transmit FSM; tx_r is loaded with the level of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (pop_s) begin
            shift_r <= fifo_rdata_s;
            state_r <= START;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            shift_r <= {1'b0, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              idx_r <= idx_r + 3'd1;
              tx_r  <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last_s) begin
            cnt_r <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (pop_s) begin
              shift_r <= fifo_rdata_s;
              state_r <= START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign Tx = tx_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4, BASE_ADDR=32'h1000). Stores push expected frames (byte and
// start cycle) into a scoreboard; a monitor watches Tx and checks every
// frame bit, start cycle and the absence of unexpected frames.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  int   pos = 0;
  int   last_start = -1000;
  exp_t cur;
  exp_t sb[$];

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .Tx  (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int p);
    int b;
    b = p / CPB;
    if (b == 0) return 1'b0;
    else if (b == 9) return 1'b1;
    else return d[b-1];
  endfunction

  // Monitor: decodes Tx on falling clock edges against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 1'b0;
      end else if (in_frame) begin
        chk("frame_bit", 32'(tx), 32'(exp_bit(cur.data, pos)));
        pos++;
        if (pos == FRAME) in_frame = 1'b0;
      end else if (tx === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'(tx), 32'd1);
        end else begin
          cur = sb.pop_front();
          chk("start_cycle", 32'(cyc), 32'(cur.start));
          chk("frame_bit", 32'(tx), 32'(exp_bit(cur.data, 0)));
          pos = 1;
          in_frame = 1'b1;
        end
      end else if (sb.size() != 0 && cyc >= sb[0].start) begin
        chk("start_missing", 32'(tx), 32'd0);
        cur = sb.pop_front();
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [7:0] d, input bit expect_tx);
    exp_t e;
    bus.MemWrite  = 1'b1;
    bus.DataAddr  = a;
    bus.WriteData = {24'hABCDEF, d};
    @(posedge clk);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    if (expect_tx) begin
      e.data  = d;
      e.start = (cyc + 1 > last_start + FRAME) ? cyc + 1 : last_start + FRAME;
      last_start = e.start;
      sb.push_back(e);
    end
  endtask

  task automatic load_check(input logic [31:0] a, input logic [31:0] exp_rd,
                            input logic exp_hit, input string nm);
    bus.MemWrite = 1'b0;
    bus.DataAddr = a;
    #1;
    chk({nm, "_rd"}, bus.ReadData, exp_rd);
    chk({nm, "_hit"}, 32'(bus.Hit), 32'(exp_hit));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = 32'h0;
    bus.WriteData = 32'h0;
    rst = 1'b0;
    @(negedge clk);
    #1 chk("reset_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Reset state and decode
    load_check(32'h1004, 32'h2, 1'b1, "status_reset");
    chk("tx_idle", 32'(tx), 32'd1);
    load_check(32'h1008, 32'h0, 1'b0, "unmapped");
    load_check(32'h1000, 32'h0, 1'b1, "txdata_read");
    @(negedge clk);

    // Single frame 0x55
    store(32'h1000, 8'h55, 1'b1);
    load_check(32'h1004, 32'h0, 1'b1, "status_after_store");
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      load_check(32'h1004, 32'h6, 1'b1, "busy_during_frame");
    end
    wait_idle(100);
    load_check(32'h1004, 32'h2, 1'b1, "status_after_frame");
    @(negedge clk);

    // Back-to-back frames
    store(32'h1000, 8'hA5, 1'b1);
    store(32'h1000, 8'h3C, 1'b1);
    wait_idle(200);
    load_check(32'h1004, 32'h2, 1'b1, "status_after_b2b");
    @(negedge clk);

    // Overflow: one in flight, four queued, sixth dropped
    store(32'h1000, 8'h01, 1'b1);
    store(32'h1000, 8'h02, 1'b1);
    store(32'h1000, 8'h03, 1'b1);
    store(32'h1000, 8'h04, 1'b1);
    store(32'h1000, 8'h05, 1'b1);
    store(32'h1000, 8'h06, 1'b0);
    load_check(32'h1004, 32'hD, 1'b1, "status_overflow");
    store(32'h1004, 8'h00, 1'b0);
    load_check(32'h1004, 32'h5, 1'b1, "status_ovf_cleared");
    wait_idle(400);
    load_check(32'h1004, 32'h2, 1'b1, "status_after_overflow");
    @(negedge clk);

    // Misaligned stores
    bus.MemWrite  = 1'b1;
    bus.DataAddr  = 32'h1001;
    bus.WriteData = 32'h77;
    #1;
    chk("misaligned1_hit", 32'(bus.Hit), 32'd0);
    chk("misaligned1_rd", bus.ReadData, 32'd0);
    @(negedge clk);
    bus.DataAddr = 32'h1002;
    #1;
    chk("misaligned2_hit", 32'(bus.Hit), 32'd0);
    @(negedge clk);
    load_check(32'h1004, 32'h2, 1'b1, "status_after_misaligned");
    repeat (10) @(negedge clk);
    chk("tx_after_misaligned", 32'(tx), 32'd1);

    // Reset mid-DATA with two bytes queued
    store(32'h1000, 8'h11, 1'b1);
    store(32'h1000, 8'h22, 1'b1);
    store(32'h1000, 8'h33, 1'b1);
    repeat (12) @(negedge clk);
    chk("pre_reset_in_frame", 32'(in_frame), 32'd1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk("reset_tx_async", 32'(tx), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    last_start = -1000;
    load_check(32'h1004, 32'h2, 1'b1, "status_after_reset");
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    chk("tx_after_reset", 32'(tx), 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the single-cycle core's data-memory bus beside the data memory. It services the core's store/load traffic (MemWrite, DataAddr, WriteData, ReadData) for a two-register window. Bytes stored to TXDATA go through a small FIFO and are serialised as 8N1 frames on `Tx`. The top level routes ReadData from this block whenever `Hit` is high.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000: word-aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `MemWrite`  in  1: store strobe from the core, single cycle per store.
- `DataAddr`  in  32: byte address from the core's ALU result.
- `WriteData`  in  32: store data; only [7:0] is used.
- `ReadData`  out  32: combinational read data for the window; 0 when `Hit`=0.
- `Hit`  out  1: combinational; 1 when `DataAddr` is BASE_ADDR+0 or BASE_ADDR+4 exactly.
- `Tx`  out  1: serial line, idle high.

## Operation
- Register map:
  - +0 TXDATA: write-only. A store pushes WriteData[7:0]. Reads return 0.
  - +4 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky). Bits [31:4] read 0.
- Address decode:
  - Any store to STATUS clears overflow.
  - DataAddr[1:0]≠0 or any other offset: `Hit`=0, no effect.
- Push: MemWrite && DataAddr==BASE_ADDR.
  - Accepted if FIFO not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Push and overflow-clear cannot coincide (different addresses).
- FSM states IDLE, START, DATA, STOP, with a baud counter 0..CLKS_PER_BIT-1 and a 3-bit bit index.
  - IDLE: Tx=1. If FIFO is non-empty, pop into the shift register and go to START, counter=0.
  - START: Tx=0. When counter==CLKS_PER_BIT-1, go to DATA with index=0.
  - DATA: Tx=shift[0], LSB first. At counter terminal: shift right; if index==7 go to STOP, else index+1.
  - STOP: Tx=1. At counter terminal: if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- The counter resets to 0 on every state change and increments otherwise.
- `Tx` is registered, driven from state and shift register flops; no combinational path from bus inputs.

## Timing
- Reset values:
  - Tx=1, state IDLE, FIFO empty (ReadData at STATUS=32'h2), overflow=0, counters 0.
  - `Hit`/ReadData remain combinational of DataAddr and state.
- First-byte latency: store at edge k makes the FIFO non-empty after edge k. The FSM pops at edge k+1, and Tx falls after edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have zero idle cycles between stop and next start.
- STATUS reflects flop state before the current edge. A load in the cycle after a store sees the pushed byte.
- Full FIFO with FSM in IDLE: that cycle's pop frees a slot, so a same-cycle push is accepted.
- Reset asserted mid-frame: Tx goes to 1 immediately (asynchronous), and queued bytes are discarded.
- Throughput limit: sustained stores faster than one per frame fill the FIFO. Extra bytes set overflow; nothing stalls the core.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - Offsets `UART_TXDATA_OFS`=0 and `UART_STATUS_OFS`=4.
  - STATUS bit-position constants.
- Sub-module `sync_fifo` (parameterised WIDTH, DEPTH):
  - push/pop/full/empty, same clock and reset.
  - Pointers carry one extra wrap bit for the full/empty distinction.
- `mmio_uart_tx` holds decode, status, FSM and shifter. Top-level ReadData muxing is outside this block.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h1000.
- Reset, then load 0x1004 → ReadData=32'h2, Tx=1, Hit=1. Load 0x1008 → Hit=0, ReadData=0.
- Store 0x1000 with data 0x55 → Tx low 4 cycles starting one edge later. Then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high 4 cycles. Busy=1 throughout; STATUS returns to 32'h2 after 40 cycles.
- Store 0xA5 then 0x3C on consecutive cycles → two 40-cycle frames with no idle cycle between the first stop and the second start.
- Six stores in six consecutive cycles while the first frame runs → five bytes transmitted (one in flight plus four queued). The sixth is dropped, and STATUS = full|busy|overflow (32'hD). A store to 0x1004 then clears bit3.
- Store to 0x1001 or 0x1002 → Hit=0, FIFO unchanged, Tx stays 1.
- Assert rst for 1 cycle mid-DATA with 2 bytes queued → Tx=1 immediately, STATUS=32'h2 after release, no further frames.
